// File: rtl/lock_pkg.sv
// Shared types and constants for the lock session controller and its helpers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lock_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_HIGH,
    S_MID,
    S_LOW,
    S_READY,
    S_JUDGE,
    S_OPEN,
    S_FAIL,
    S_LOCKOUT
  } state_t;

  localparam logic [2:0] STG_HIGH = 3'b001;
  localparam logic [2:0] STG_MID  = 3'b010;
  localparam logic [2:0] STG_LOW  = 3'b100;

  localparam logic [3:0] DIGIT_ERR = 4'b1110;

  // Entry-register write lane owned by each digit-collection state.
  function automatic logic [2:0] stage_bit(input state_t s);
    case (s)
      S_HIGH:  stage_bit = STG_HIGH;
      S_MID:   stage_bit = STG_MID;
      S_LOW:   stage_bit = STG_LOW;
      default: stage_bit = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/tick_down_counter.sv
// Loadable down-counter stepped by the timebase strobe; flags the strobe that reaches zero.
// Latency: expire is combinational on tick; count updates on the next clk.
// Backpressure: none; load has priority over a same-cycle tick, and the count never wraps.
module tick_down_counter #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         tick,
  output logic         expire
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (tick && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign expire = tick && (cnt == W'(1));

endmodule

// File: rtl/lock_session_controller.sv
// Sequences one unlock attempt: digit-pair stages, judge, open period, failure count and lockout.
// Latency: registered state; stage_we is combinational, other outputs follow state by one clk.
// Backpressure: none; pulses outside their accepting state are dropped, LOCKOUT ignores all user input.
module lock_session_controller
  import lock_pkg::*;
#(
  parameter int MAX_ERR       = 3,
  parameter int UNLOCK_TICKS  = 5,
  parameter int LOCKOUT_TICKS = 30
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       tick,
  input  logic       m,
  input  logic       digit_valid,
  input  logic       enter,
  input  logic       cancel,
  input  logic       match,
  output logic [2:0] stage_we,
  output logic       judge_en,
  output logic       entry_clr,
  output logic       unlock,
  output logic [1:0] error_count,
  output logic       led,
  output logic       locked_out
);

  localparam int MAXT = (UNLOCK_TICKS > LOCKOUT_TICKS) ? UNLOCK_TICKS : LOCKOUT_TICKS;
  localparam int CW   = $clog2(MAXT + 1);

  state_t        state, state_nxt;
  logic          clr_q, clr_nxt;
  logic          load;
  logic [CW-1:0] load_val;
  logic          expire;

  tick_down_counter #(.W(CW)) u_tick_cnt (
    .clk      (clk),
    .clr      (clr),
    .load     (load),
    .load_val (load_val),
    .tick     (tick),
    .expire   (expire)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= S_IDLE;
      clr_q <= 1'b0;
    end else begin
      state <= state_nxt;
      clr_q <= clr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    clr_nxt   = 1'b0;
    case (state)
      S_IDLE: begin
        if (m) begin
          state_nxt = S_HIGH;
          clr_nxt   = 1'b1;
        end
      end
      S_HIGH, S_MID, S_LOW, S_READY: begin
        // Mode drop beats cancel, which beats any digit/enter in the same cycle.
        if (!m) begin
          state_nxt = S_IDLE;
          clr_nxt   = 1'b1;
        end else if (cancel) begin
          state_nxt = S_HIGH;
          clr_nxt   = 1'b1;
        end else if (state == S_READY) begin
          if (enter) state_nxt = S_JUDGE;
        end else if (digit_valid) begin
          state_nxt = (state == S_HIGH) ? S_MID : (state == S_MID) ? S_LOW : S_READY;
        end
      end
      S_JUDGE: begin
        if (!m) begin
          state_nxt = S_IDLE;
          clr_nxt   = 1'b1;
        end else begin
          state_nxt = match ? S_OPEN : S_FAIL;
        end
      end
      S_FAIL: begin
        if (!m) begin
          state_nxt = S_IDLE;
          clr_nxt   = 1'b1;
        end else begin
          state_nxt = (int'(error_count) >= MAX_ERR) ? S_LOCKOUT : S_HIGH;
        end
      end
      S_OPEN: begin
        if (expire) begin
          state_nxt = S_IDLE;
          clr_nxt   = 1'b1;
        end
      end
      S_LOCKOUT: begin
        if (expire) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Every state change reloads the counter, so a tick on the entry edge is never counted.
  always_comb begin
    load     = (state_nxt != state);
    load_val = '0;
    if (state_nxt == S_OPEN) begin
      load_val = CW'(UNLOCK_TICKS);
    end else if (state_nxt == S_LOCKOUT) begin
      load_val = CW'(LOCKOUT_TICKS);
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      error_count <= 2'd0;
    end else if (state == S_JUDGE) begin
      if (match) error_count <= 2'd0;
      else       error_count <= (error_count == 2'd3) ? 2'd3 : error_count + 2'd1;
    end else if ((state == S_LOCKOUT) && expire) begin
      error_count <= 2'd0;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      led <= 1'b0;
    end else if ((state == S_LOCKOUT) && tick) begin
      led <= expire ? 1'b0 : ~led;
    end
  end

  assign stage_we   = stage_bit(state) & {3{digit_valid & ~cancel}};
  assign judge_en   = (state == S_JUDGE);
  assign entry_clr  = clr_q | (state == S_FAIL);
  assign unlock     = (state == S_OPEN);
  assign locked_out = (state == S_LOCKOUT);

endmodule

// File: tb/tb_lock_session_controller.sv
// Randomized scenario bench for lock_session_controller with an arithmetic reference model.
module tb_lock_session_controller;

  logic       clk = 1'b0;
  logic       clr, tick, m, digit_valid, enter, cancel, match;
  logic [2:0] stage_we;
  logic       judge_en, entry_clr, unlock, led, locked_out;
  logic [1:0] error_count;

  int n_vec  = 0;
  int n_miss = 0;
  int exp_err = 0;

  localparam logic [8:0] WE_SEQ = {3'b100, 3'b010, 3'b001};

  lock_session_controller dut (
    .clk         (clk),
    .clr         (clr),
    .tick        (tick),
    .m           (m),
    .digit_valid (digit_valid),
    .enter       (enter),
    .cancel      (cancel),
    .match       (match),
    .stage_we    (stage_we),
    .judge_en    (judge_en),
    .entry_clr   (entry_clr),
    .unlock      (unlock),
    .error_count (error_count),
    .led         (led),
    .locked_out  (locked_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    digit_valid = 1'b0;
    enter       = 1'b0;
    cancel      = 1'b0;
    tick        = 1'b0;
  endtask

  // Drives one complete entry from HIGH through JUDGE with random gaps and ignored-input noise.
  task automatic run_entry(input logic match_v, input logic tick_judge,
                           output logic [8:0] we_all, output logic jud_a, output logic jud_b);
    int gap;
    we_all = '0;
    for (int k = 0; k < 3; k++) begin
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        tick  = 1'($urandom_range(0, 1));
        enter = 1'($urandom_range(0, 1));
        step();
      end
      digit_valid = 1'b1;
      #1;
      we_all[3*k +: 3] = stage_we;
      step();
    end
    gap = $urandom_range(0, 2);
    for (int g = 0; g < gap; g++) begin
      digit_valid = 1'($urandom_range(0, 1));
      tick        = 1'($urandom_range(0, 1));
      step();
    end
    match = match_v;
    enter = 1'b1;
    step();
    jud_a = judge_en;
    tick  = tick_judge;
    step();
    jud_b = judge_en;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (stage_we !== 3'b000) begin n_miss++; $display("FAIL reset_stage_we: got %b want 000", stage_we); end
    n_vec++; if (judge_en !== 1'b0) begin n_miss++; $display("FAIL reset_judge_en: got %b want 0", judge_en); end
    n_vec++; if (entry_clr !== 1'b0) begin n_miss++; $display("FAIL reset_entry_clr: got %b want 0", entry_clr); end
    n_vec++; if (unlock !== 1'b0) begin n_miss++; $display("FAIL reset_unlock: got %b want 0", unlock); end
    n_vec++; if (error_count !== 2'd0) begin n_miss++; $display("FAIL reset_error_count: got %0d want 0", error_count); end
    n_vec++; if (led !== 1'b0) begin n_miss++; $display("FAIL reset_led: got %b want 0", led); end
    n_vec++; if (locked_out !== 1'b0) begin n_miss++; $display("FAIL reset_locked_out: got %b want 0", locked_out); end
    clr = 1'b0;
    step();
  endtask

  task automatic test_unlock();
    logic [8:0] we;
    logic ja, jb;
    int n;
    bit done;
    m = 1'b1;
    step();
    n_vec++; if (entry_clr !== 1'b1) begin n_miss++; $display("FAIL unlock_entry_clr_start: got %b want 1", entry_clr); end
    run_entry(1'b1, 1'b1, we, ja, jb);
    exp_err = 0;
    n_vec++; if (we !== WE_SEQ) begin n_miss++; $display("FAIL unlock_stage_seq: got %b want %b", we, WE_SEQ); end
    n_vec++; if ({ja, jb} !== 2'b10) begin n_miss++; $display("FAIL unlock_judge_pulse: got %b want 10", {ja, jb}); end
    n_vec++; if (unlock !== 1'b1) begin n_miss++; $display("FAIL unlock_open: got %b want 1", unlock); end
    n_vec++; if (error_count !== 2'(exp_err)) begin n_miss++; $display("FAIL unlock_err: got %0d want %0d", error_count, exp_err); end
    // Mode drop during the open period must not shorten it.
    m = 1'b0;
    step();
    n = 0;
    done = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      tick = 1'($urandom_range(0, 1));
      n += int'(tick);
      step();
      n_vec++; if (unlock !== (n < 5)) begin n_miss++; $display("FAIL unlock_hold: ticks %0d got %b want %b", n, unlock, (n < 5)); end
      if (n == 5) begin
        done = 1;
        n_vec++; if (entry_clr !== 1'b1) begin n_miss++; $display("FAIL unlock_exit_clr: got %b want 1", entry_clr); end
      end
    end
    if (!done) begin n_vec++; n_miss++; $display("FAIL unlock_timeout: got %0d ticks want 5", n); end
    digit_valid = 1'b1;
    #1;
    n_vec++; if (stage_we !== 3'b000) begin n_miss++; $display("FAIL idle_stage_we: got %b want 000", stage_we); end
    step();
  endtask

  task automatic test_fail_then_success();
    logic [8:0] we;
    logic ja, jb;
    m = 1'b1;
    step();
    for (int i = 0; i < 2; i++) begin
      run_entry(1'b0, 1'b0, we, ja, jb);
      exp_err = (exp_err >= 3) ? 3 : exp_err + 1;
      n_vec++; if (error_count !== 2'(exp_err)) begin n_miss++; $display("FAIL fts_err: got %0d want %0d", error_count, exp_err); end
      n_vec++; if (entry_clr !== 1'b1) begin n_miss++; $display("FAIL fts_fail_clr: got %b want 1", entry_clr); end
      step();
    end
    run_entry(1'b1, 1'b0, we, ja, jb);
    exp_err = 0;
    n_vec++; if (error_count !== 2'(exp_err)) begin n_miss++; $display("FAIL fts_err_clear: got %0d want 0", error_count); end
    n_vec++; if (unlock !== 1'b1) begin n_miss++; $display("FAIL fts_unlock: got %b want 1", unlock); end
    m = 1'b0;
    step();
    repeat (5) begin tick = 1'b1; step(); end
    n_vec++; if (unlock !== 1'b0) begin n_miss++; $display("FAIL fts_unlock_end: got %b want 0", unlock); end
  endtask

  task automatic test_three_failures();
    logic [8:0] we;
    logic ja, jb;
    m = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      run_entry(1'b0, 1'($urandom_range(0, 1)), we, ja, jb);
      exp_err = (exp_err >= 3) ? 3 : exp_err + 1;
      n_vec++; if (we !== WE_SEQ) begin n_miss++; $display("FAIL tf_stage_seq: got %b want %b", we, WE_SEQ); end
      n_vec++; if ({ja, jb} !== 2'b10) begin n_miss++; $display("FAIL tf_judge_pulse: got %b want 10", {ja, jb}); end
      n_vec++; if (error_count !== 2'(exp_err)) begin n_miss++; $display("FAIL tf_err: got %0d want %0d", error_count, exp_err); end
      step();
      n_vec++; if (locked_out !== (exp_err >= 3)) begin n_miss++; $display("FAIL tf_locked_out: got %b want %b", locked_out, (exp_err >= 3)); end
    end
    n_vec++; if (led !== 1'b0) begin n_miss++; $display("FAIL tf_led_start: got %b want 0", led); end
  endtask

  task automatic test_lockout_immunity();
    int n;
    bit done;
    logic t;
    step();
    n = 0;
    done = 0;
    for (int c = 0; c < 2000 && !done; c++) begin
      m           = 1'($urandom_range(0, 1));
      enter       = 1'($urandom_range(0, 1));
      digit_valid = 1'($urandom_range(0, 1));
      cancel      = 1'($urandom_range(0, 1));
      tick        = 1'($urandom_range(0, 1));
      t = tick;
      #1;
      n_vec++; if (stage_we !== 3'b000) begin n_miss++; $display("FAIL lo_stage_we: got %b want 000", stage_we); end
      step();
      n += int'(t);
      if (n < 30) begin
        n_vec++; if ({locked_out, unlock, judge_en} !== 3'b100) begin n_miss++; $display("FAIL lo_state: got %b want 100", {locked_out, unlock, judge_en}); end
        n_vec++; if (led !== 1'(n % 2)) begin n_miss++; $display("FAIL lo_led: ticks %0d got %b want %b", n, led, 1'(n % 2)); end
        n_vec++; if (error_count !== 2'd3) begin n_miss++; $display("FAIL lo_err_hold: got %0d want 3", error_count); end
      end else begin
        done = 1;
        exp_err = 0;
        n_vec++; if ({locked_out, led} !== 2'b00) begin n_miss++; $display("FAIL lo_end: got %b want 00", {locked_out, led}); end
        n_vec++; if (error_count !== 2'(exp_err)) begin n_miss++; $display("FAIL lo_end_err: got %0d want 0", error_count); end
      end
    end
    if (!done) begin n_vec++; n_miss++; $display("FAIL lo_timeout: got %0d ticks want 30", n); end
    m = 1'b0;
    step();
  endtask

  task automatic test_cancel_collision();
    logic [8:0] we;
    logic ja, jb;
    m = 1'b1;
    step();
    run_entry(1'b0, 1'b0, we, ja, jb);
    exp_err = exp_err + 1;
    step();
    digit_valid = 1'b1;
    step();
    cancel = 1'b1;
    digit_valid = 1'b1;
    #1;
    n_vec++; if (stage_we !== 3'b000) begin n_miss++; $display("FAIL cc_stage_we: got %b want 000", stage_we); end
    step();
    n_vec++; if (entry_clr !== 1'b1) begin n_miss++; $display("FAIL cc_entry_clr: got %b want 1", entry_clr); end
    n_vec++; if (error_count !== 2'(exp_err)) begin n_miss++; $display("FAIL cc_err: got %0d want %0d", error_count, exp_err); end
    digit_valid = 1'b1;
    #1;
    n_vec++; if (stage_we !== 3'b001) begin n_miss++; $display("FAIL cc_back_high: got %b want 001", stage_we); end
    step();
    repeat (2) begin digit_valid = 1'b1; step(); end
    cancel = 1'b1;
    enter  = 1'b1;
    step();
    n_vec++; if ({judge_en, entry_clr} !== 2'b01) begin n_miss++; $display("FAIL cc_ready_cancel: got %b want 01", {judge_en, entry_clr}); end
    digit_valid = 1'b1;
    #1;
    n_vec++; if (stage_we !== 3'b001) begin n_miss++; $display("FAIL cc_ready_high: got %b want 001", stage_we); end
    step();
    m = 1'b0;
    step();
    n_vec++; if (entry_clr !== 1'b1) begin n_miss++; $display("FAIL cc_mode_drop_clr: got %b want 1", entry_clr); end
  endtask

  task automatic test_async_reset();
    logic [8:0] we;
    logic ja, jb;
    m = 1'b1;
    step();
    run_entry(1'b1, 1'b0, we, ja, jb);
    n_vec++; if (unlock !== 1'b1) begin n_miss++; $display("FAIL ar_open: got %b want 1", unlock); end
    step();
    tick = 1'b1;
    step();
    #3;
    clr = 1'b1;
    #1;
    n_vec++; if (unlock !== 1'b0) begin n_miss++; $display("FAIL ar_unlock_drop: got %b want 0", unlock); end
    n_vec++; if ({stage_we, judge_en, entry_clr, error_count, led, locked_out} !== 9'd0) begin
      n_miss++; $display("FAIL ar_outputs: got %b want 0", {stage_we, judge_en, entry_clr, error_count, led, locked_out});
    end
    @(posedge clk);
    #2;
    clr = 1'b0;
    exp_err = 0;
    step();
    n_vec++; if (entry_clr !== 1'b1) begin n_miss++; $display("FAIL ar_restart_clr: got %b want 1", entry_clr); end
    digit_valid = 1'b1;
    #1;
    n_vec++; if (stage_we !== 3'b001) begin n_miss++; $display("FAIL ar_restart_high: got %b want 001", stage_we); end
    step();
    m = 1'b0;
    step();
  endtask

  initial begin
    clr = 1'b1; tick = 1'b0; m = 1'b0; digit_valid = 1'b0;
    enter = 1'b0; cancel = 1'b0; match = 1'b0;
    test_reset();
    test_unlock();
    test_fail_then_success();
    test_three_failures();
    test_lockout_immunity();
    test_cancel_collision();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/lock_session_controller.md
Name: lock_session_controller

Overview:
- Sequences one unlock attempt on the six-digit lock datapath.
- Steps the entry register through its high, mid and low digit-pair write stages, then strobes the comparator.
- Counts consecutive failures and enforces a timed lockout with LED flashing.
- Owns the unlock output.
- Sits between the keypad/digit inputs and the password/entry registers plus comparators, replacing ad-hoc decoder-driven stage selection.

Parameters:
- MAX_ERR, 3, consecutive failures that trigger lockout (1..3).
- UNLOCK_TICKS, 5, tick strobes the unlock output stays high.
- LOCKOUT_TICKS, 30, tick strobes lockout lasts.

Ports:
- clk  in  1  system clock.
- clr  in  1  reset, asynchronous, active-high.
- tick  in  1  one-clk-wide timebase strobe from the timer.
- m  in  1  mode: 1 = verify/unlock, 0 = password-set (controller idle).
- digit_valid  in  1  one-clk pulse; a digit pair is present on the datapath.
- enter  in  1  one-clk pulse; submit the entry.
- cancel  in  1  one-clk pulse; abort the attempt.
- match  in  1  OR of comparator results; sampled only while judge_en=1.
- stage_we  out  3  one-hot write enable to the entry register: bit0 high pair, bit1 mid, bit2 low.
- judge_en  out  1  comparator enable.
- entry_clr  out  1  clears the entry register.
- unlock  out  1  lock open.
- error_count  out  2  consecutive failures.
- led  out  1  lockout flash.
- locked_out  out  1  high while in LOCKOUT.

Behaviour:
- States: IDLE, HIGH, MID, LOW, READY, JUDGE, OPEN, FAIL, LOCKOUT. Registered state; Moore outputs except stage_we.
- Reset (clr=1, async): state=IDLE, error_count=0, tick counter=0, unlock=0, led=0, judge_en=0, entry_clr=0, locked_out=0.
- stage_we:
  - Combinational: equals the stage bit of HIGH/MID/LOW AND digit_valid AND NOT cancel.
  - Zero in every other state.
- IDLE: if m=1, go to HIGH next cycle with entry_clr=1 for that cycle. If m=0, stay.
- HIGH -> MID -> LOW -> READY: each transition happens on digit_valid.
- READY:
  - digit_valid is ignored.
  - enter moves to JUDGE.
  - enter in HIGH/MID/LOW is ignored.
- JUDGE (exactly 1 clk, judge_en=1):
  - match=1 -> OPEN, error_count<=0.
  - match=0 -> FAIL, error_count<=error_count+1.
- FAIL (1 clk, entry_clr=1):
  - If the new error_count >= MAX_ERR -> LOCKOUT.
  - Otherwise -> HIGH.
- OPEN:
  - unlock=1.
  - Counts tick strobes; after UNLOCK_TICKS strobes -> IDLE with entry_clr=1.
  - A tick arriving in the entry cycle is not counted.
- LOCKOUT:
  - locked_out=1.
  - led toggles on every tick, starting from 0.
  - After LOCKOUT_TICKS strobes: led<=0, error_count<=0, -> IDLE.
  - cancel, m, digit_valid and enter are all ignored.
- cancel: in HIGH/MID/LOW/READY, moves to HIGH with entry_clr=1. cancel wins over a simultaneous digit_valid or enter. error_count is unchanged.
- m falls to 0:
  - In any state except LOCKOUT and OPEN: -> IDLE with entry_clr=1 next cycle.
  - In OPEN: the open period still completes.
  - In LOCKOUT: no effect.
- Tick counter:
  - Width is clog2(max(UNLOCK_TICKS, LOCKOUT_TICKS)+1).
  - Cleared on every state entry; never wraps.
- error_count saturates at 3.

Decomposition:
- Shared package (lock_pkg) holds:
  - state encoding enum;
  - stage one-hot constants STG_HIGH=3'b001, STG_MID=3'b010, STG_LOW=3'b100;
  - the digit-error code 4'b1110.
- One natural sub-module: tick_down_counter. Loadable down-counter decremented on tick; flags zero. Shared by OPEN and LOCKOUT.

Test Plan:
- Correct unlock:
  - Stimulus: m=1; three digit_valid pulses then enter; match=1 in JUDGE.
  - Required: stage_we sequence 001, 010, 100; judge_en high exactly 1 clk; unlock high for 5 ticks; return to IDLE; error_count=0.
- Three failures:
  - Stimulus: three full entries with match=0.
  - Required: error_count goes 1, 2, 3; LOCKOUT entered on the third; led toggles each tick; after 30 ticks led=0, error_count=0, state IDLE.
- Cancel collision:
  - Stimulus: cancel with digit_valid in the same cycle during MID.
  - Required: stage_we=000; state HIGH; entry_clr=1; error_count unchanged.
- Lockout immunity:
  - Stimulus: during LOCKOUT, toggle m and pulse enter/digit_valid.
  - Required: no state change, stage_we=0, lockout ends on schedule.
- Async reset:
  - Stimulus: assert clr mid-OPEN between clk edges.
  - Required: unlock drops immediately; all outputs at reset values; restart from IDLE after clr release.
- Failure then success:
  - Stimulus: error_count=2, then match=1.
  - Required: error_count=0 and unlock=1.
